// File: rtl/mmu_pkg.sv
// Shared types and encodings for the mmu TLB-refill sequencer.
// Used by mmu_refill and mmu_refill_timeout.
package mmu_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_CHECK = 3'd2,
        S_WSEL  = 3'd3,
        S_WENT  = 3'd4,
        S_DONE  = 3'd5,
        S_FAULT = 3'd6
    } refill_state_e;

    localparam int PTE_VALID = 1;
    localparam int PTE_WRITE = 2;

    // bit0 of an mmu reg_data word selects fault register vs entry
    localparam logic REG_SEL_FAULT = 1'b0;
    localparam logic REG_SEL_ENTRY = 1'b1;

endpackage

// File: rtl/mmu_refill_timeout.sv
// Watchdog for the PTE fetch: fires after TIMEOUT fetch cycles without ack.
// Only instantiated when MMU_REFILL_TIMEOUT_EN is defined.
module mmu_refill_timeout
    import mmu_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset_n,
    input  logic fetch,
    input  logic ack,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // leaving FETCH clears the count, so every FETCH entry starts at zero
    always_comb begin
        cnt_d = '0;
        if (fetch && !ack) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = fetch && !ack && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mmu_refill.sv
// Hardware TLB-refill sequencer: fetches one PTE and installs it via mmu reg_write.
// Optional fetch watchdog enabled by defining MMU_REFILL_TIMEOUT_EN.
module mmu_refill
    import mmu_pkg::*;
#(
    parameter int RV      = 16,
    parameter int PA      = RV,
    parameter int VA      = RV,
    parameter int NMMU    = 8,
    parameter int TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic                     miss_req,
    input  logic                     miss_is_pc,
    input  logic                     miss_sup,
    input  logic [$clog2(NMMU)-1:0]  miss_vpn,
    input  logic                     inv_any,
    input  logic                     ptb_write,
    input  logic [PA-1:0]            ptb_data,
    output logic [PA-1:0]            ptb_read,
    output logic                     stall,
    output logic                     refill_done,
    output logic                     refill_fault,
    output logic                     mem_req,
    output logic [PA-1:0]            mem_addr,
    input  logic                     mem_ack,
    input  logic [RV-1:0]            mem_rdata,
    output logic                     mmu_reg_write,
    output logic [RV-1:0]            mmu_reg_data
);

    localparam int VW      = $clog2(NMMU);
    localparam int KW      = VW + 2;
    localparam int BSH     = $clog2(RV / 8);
    localparam int PTB_LSB = $clog2(4 * NMMU * RV / 8);
    localparam int unused_va = VA;

    refill_state_e state_q, state_d;
    logic [KW-1:0] key_q, key_d;
    logic [RV-1:1] pte_q, pte_d;
    logic [PA-1:0] ptb_q, ptb_d;
    logic          restart_q, restart_d;
    logic          timeout_hit;
    logic          evt;
    logic          unused_rdata0;

    assign unused_rdata0 = mem_rdata[0];
    assign evt = inv_any | ptb_write;

`ifdef MMU_REFILL_TIMEOUT_EN
    mmu_refill_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .reset_n (reset_n),
        .fetch   (state_q == S_FETCH),
        .ack     (mem_ack),
        .expire  (timeout_hit)
    );
`else
    localparam int unused_timeout = TIMEOUT;
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            key_q     <= '0;
            pte_q     <= '0;
            ptb_q     <= '0;
            restart_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            key_q     <= key_d;
            pte_q     <= pte_d;
            ptb_q     <= ptb_d;
            restart_q <= restart_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        key_d         = key_q;
        pte_d         = pte_q;
        ptb_d         = ptb_q;
        restart_d     = restart_q;
        mem_req       = 1'b0;
        mem_addr      = '0;
        mmu_reg_write = 1'b0;
        mmu_reg_data  = '0;
        refill_done   = 1'b0;
        refill_fault  = 1'b0;
        stall         = (state_q != S_IDLE);

        if (ptb_write) begin
            ptb_d = {ptb_data[PA-1:PTB_LSB], {PTB_LSB{1'b0}}};
        end

        unique case (state_q)
            S_IDLE: begin
                restart_d = 1'b0;
                if (miss_req && enable) begin
                    key_d   = {miss_is_pc, miss_sup, miss_vpn};
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                mem_req  = 1'b1;
                mem_addr = ptb_q + (PA'(key_q) << BSH);
                if (evt) begin
                    restart_d = 1'b1;
                end
                if (mem_ack) begin
                    pte_d   = mem_rdata[RV-1:1];
                    state_d = S_CHECK;
                end else if (timeout_hit) begin
                    state_d = S_FAULT;
                end
            end
            // a table change seen during fetch/check makes the PTE stale
            S_CHECK: begin
                restart_d = 1'b0;
                if (restart_q || evt) begin
                    state_d = S_FETCH;
                end else if (!pte_q[PTE_VALID]) begin
                    state_d = S_FAULT;
                end else begin
                    state_d = S_WSEL;
                end
            end
            S_WSEL: begin
                mmu_reg_write = 1'b1;
                mmu_reg_data  = {key_q[VW-1:0], {(RV-VW-4){1'b0}},
                                 key_q[VW+1], key_q[VW], 1'b1, REG_SEL_FAULT};
                state_d       = S_WENT;
            end
            S_WENT: begin
                mmu_reg_write = 1'b1;
                mmu_reg_data  = {pte_q[RV-1:3], pte_q[PTE_WRITE],
                                 1'b1, REG_SEL_ENTRY};
                state_d       = S_DONE;
            end
            S_DONE: begin
                refill_done = 1'b1;
                state_d     = S_IDLE;
            end
            S_FAULT: begin
                refill_fault = 1'b1;
                state_d      = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign ptb_read = ptb_q;

endmodule
